// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmit path: FSM encoding,
// error codes, common keyboard command bytes and the debug view of the block.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        XMIT      = 3'd2,
        WAIT_IDLE = 3'd3,
        DONE      = 3'd4,
        FAIL      = 3'd5
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Bit-counter values (falls already seen) at which the frame changes phase.
    localparam logic [3:0] BITS_PARITY = 4'd8;
    localparam logic [3:0] BITS_STOP   = 4'd9;
    localparam logic [3:0] BITS_ACK    = 4'd10;

    // Observable internals: FSM state plus the conditioned line levels/edges.
    typedef struct packed {
        ps2_state_t state;
        logic       clk_level;
        logic       dat_level;
        logic       clk_fall;
        logic       dat_fall;
    } ps2_dbg_t;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of 1s.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pad: 2-FF synchronizer followed by an agreement
// filter that only accepts a new level after FILT_LEN consecutive equal
// samples. fall pulses for one cycle when the filtered level goes 1 -> 0.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] agree_cnt;

    // Two-stage synchronizer; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_in;
            sync2 <= sync1;
        end
    end

    // Agreement filter: count consecutive samples that disagree with the
    // accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= 1'b1;
            agree_cnt <= '0;
            fall      <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync2 != level) begin
                if (agree_cnt == CW'(FILT_LEN - 1)) begin
                    level     <= sync2;
                    agree_cnt <= '0;
                    fall      <= level;
                end else begin
                    agree_cnt <= agree_cnt + 1'b1;
                end
            end else begin
                agree_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// shifts a command byte out on device clock falls and checks the device ACK.
// Both lines are driven open-drain through the *_oe outputs (1 = pull low).
//
// Request handshake: tx_start is a single-cycle request that is accepted only
// in a cycle where tx_busy is low; tx_data is captured in that same cycle.
// tx_busy stays high from the cycle after acceptance until the FSM is back in
// IDLE, and the frame ends with exactly one tx_done or tx_error pulse (none if
// reset interrupts it). Requests made while busy are dropped, not queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILT_LEN       = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output ps2_dbg_t   dbg
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    ps2_state_t       state;
    ps2_state_t       state_nxt;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [1:0]       err_q;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       bit_cnt;
    logic             xmit_oe_q;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall;

    logic inh_last;
    logic to_hit;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk    (CLOCK_50),
        .reset  (reset),
        .pad_in (ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk    (CLOCK_50),
        .reset  (reset),
        .pad_in (ps2_dat_in),
        .level  (dat_level),
        .fall   (dat_fall)
    );

    assign inh_last = (state == INHIBIT) && (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a timeout wins over any bit activity in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tx_start) state_nxt = INHIBIT;
            INHIBIT:   if (inh_last) state_nxt = XMIT;
            XMIT: begin
                if (to_hit) begin
                    state_nxt = FAIL;
                end else if (clk_fall && (bit_cnt == BITS_ACK)) begin
                    state_nxt = dat_level ? FAIL : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (to_hit) begin
                    state_nxt = FAIL;
                end else if (clk_level && dat_level) begin
                    state_nxt = DONE;
                end
            end
            DONE:      state_nxt = IDLE;
            FAIL:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Frame datapath: captured byte, counters, per-bit data drive and error code.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            data_q    <= '0;
            parity_q  <= 1'b0;
            err_q     <= ERR_NONE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            xmit_oe_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        data_q   <= tx_data;
                        parity_q <= odd_parity(tx_data);
                        err_q    <= ERR_NONE;
                        inh_cnt  <= '0;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_last) begin
                        to_cnt    <= '0;
                        bit_cnt   <= '0;
                        xmit_oe_q <= 1'b1;  // keep the start bit on the line
                    end
                end
                XMIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else if (clk_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // bit_cnt is the number of falls before this one.
                        if (bit_cnt < BITS_PARITY) begin
                            xmit_oe_q <= ~data_q[bit_cnt[2:0]];
                        end else if (bit_cnt == BITS_PARITY) begin
                            xmit_oe_q <= ~parity_q;
                        end else if (bit_cnt == BITS_STOP) begin
                            xmit_oe_q <= 1'b0;
                        end else if (bit_cnt == BITS_ACK) begin
                            if (dat_level) err_q <= ERR_NOACK;
                        end
                    end
                end
                WAIT_IDLE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_hit) err_q <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    // Line drives and status are decoded from state so reset releases the bus
    // on the very next edge and FAIL always frees both lines.
    always_comb begin
        tx_busy    = (state != IDLE);
        tx_done    = (state == DONE);
        tx_error   = (state == FAIL);
        ps2_clk_oe = (state == INHIBIT);
        ps2_dat_oe = inh_last || ((state == XMIT) && xmit_oe_q);
        err_code   = err_q;
        dbg        = '{state: state, clk_level: clk_level, dat_level: dat_level,
                       clk_fall: clk_fall, dat_fall: dat_fall};
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a table of command frames played against a
// simple PS/2 device model, plus hand-written timeout and mid-frame reset runs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 5000;
    localparam int TOUT = 2000;
    localparam int HALF = 40;

    // ---------------- clock / reset ----------------
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_dat_oe;
    ps2_dbg_t   dbg;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic glitch      = 1'b0;
    wire  ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
    wire  ps2_dat_in  = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILT_LEN(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .dbg        (dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts done/error pulses and snapshots the lines at and
    // one cycle after each error pulse.
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic [1:0] snap_fail = 2'b11;
    logic [2:0] snap_after = 3'b111;
    logic       snap_pending = 1'b0;
    always @(negedge CLOCK_50) begin
        if (snap_pending) begin
            snap_after   <= {ps2_clk_oe, ps2_dat_oe, tx_busy};
            snap_pending <= 1'b0;
        end
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt      <= err_cnt + 1;
            snap_fail    <= {ps2_clk_oe, ps2_dat_oe};
            snap_pending <= 1'b1;
        end
    end

    // Run-time guard so a stuck design cannot hang the run.
    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Issue a request, then measure how long the host holds the clock low and
    // which cycles of that window also drive data low.
    task automatic start_frame(input logic [7:0] d, input bit poke, output int inh,
                               output logic dprev, output logic dlast, output logic busy0);
        @(negedge CLOCK_50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
        busy0 = tx_busy;
        inh = 0; dprev = 1'b0; dlast = 1'b0;
        while (ps2_clk_oe === 1'b1 && inh < 10000) begin
            dprev = dlast;
            dlast = ps2_dat_oe;
            inh++;
            if (poke && inh == 100) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge CLOCK_50);
        end
    endtask

    // One device clock period; the line is read at the rising edge.
    task automatic dev_clock(input bit do_glitch, output logic b);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        b = ps2_dat_in;
        if (do_glitch) begin
            repeat (10) @(negedge CLOCK_50);
            glitch = 1'b1;
            repeat (2) @(negedge CLOCK_50);
            glitch = 1'b0;
            repeat (HALF - 12) @(negedge CLOCK_50);
        end else begin
            repeat (HALF) @(negedge CLOCK_50);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         pre_reset;
        bit         poke;
        bit         glitch;
        logic [9:0] exp_bits;   // [0] first data bit ... [8] parity, [9] stop
        logic [1:0] exp_err;
        int         exp_done;
        int         exp_fail;
    } frame_t;

    frame_t frames[5];

    task automatic reset_midframe();
        int inh; logic dp, dl, b0, b;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_frame(CMD_SET_LED, 1'b0, inh, dp, dl, b0);
        repeat (30) @(negedge CLOCK_50);
        for (int k = 1; k <= 4; k++) dev_clock(1'b0, b);
        dev_clk_low = 1'b1;                      // fall 5
        repeat (20) @(negedge CLOCK_50);
        chk("rstmid_dat_oe_before", ps2_dat_oe, 1'b1);  // bit4 of 0xED is 0
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("rstmid_clk_oe", ps2_clk_oe, 1'b0);
        chk("rstmid_dat_oe", ps2_dat_oe, 1'b0);
        chk("rstmid_busy", tx_busy, 1'b0);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_no_err", err_cnt - e0, 0);
        chk("rstmid_err_code", err_code, ERR_NONE);
    endtask

    task automatic run_frame(input int idx, input frame_t f);
        int inh, c, d0, e0;
        logic dp, dl, b0, b;
        logic [10:0] bits;
        string p;
        p = $sformatf("f%0d_%02h", idx, f.data);
        d0 = done_cnt; e0 = err_cnt;
        start_frame(f.data, f.poke, inh, dp, dl, b0);
        chk({p, "_busy"}, b0, 1'b1);
        chk({p, "_inhibit_len"}, inh, INH);
        chk({p, "_start_early"}, dp, 1'b0);
        chk({p, "_start_last"}, dl, 1'b1);
        repeat (30) @(negedge CLOCK_50);
        bits = '0;
        bits[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clock(f.glitch && k == 3, b);
            bits[k] = b;
        end
        if (f.ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;                      // fall 11
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
        c = 0;
        while (done_cnt == d0 && err_cnt == e0 && c < 3000) begin
            @(negedge CLOCK_50);
            c++;
        end
        repeat (20) @(negedge CLOCK_50);
        chk({p, "_start_bit"}, bits[0], 1'b0);
        chk({p, "_line_bits"}, bits[10:1], f.exp_bits);
        chk({p, "_done_cnt"}, done_cnt - d0, f.exp_done);
        chk({p, "_err_cnt"}, err_cnt - e0, f.exp_fail);
        chk({p, "_err_code"}, err_code, f.exp_err);
        chk({p, "_idle_busy"}, tx_busy, 1'b0);
        if (f.exp_fail != 0) begin
            chk({p, "_fail_oe"}, snap_fail, 2'b00);
            chk({p, "_after_fail"}, snap_after, 3'b000);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int inh, c;
        logic dp, dl, b0;

        frames[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3ED, ERR_NONE,  1, 0};
        frames[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, ERR_NONE,  1, 0};
        frames[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h300, ERR_NOACK, 0, 1};
        frames[3] = '{8'hF4, 1'b1, 1'b1, 1'b0, 1'b0, 10'h2F4, ERR_NONE,  1, 0};
        frames[4] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3ED, ERR_NONE,  1, 0};

        repeat (5) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_error", tx_error, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_dat_oe", ps2_dat_oe, 1'b0);
        chk("rst_state", 32'(dbg.state), 32'(IDLE));
        repeat (20) @(negedge CLOCK_50);

        for (int i = 0; i < 5; i++) begin
            if (frames[i].pre_reset) reset_midframe();
            run_frame(i, frames[i]);
        end

        // Device that never clocks: error must land TOUT cycles after release.
        start_frame(CMD_RESET, 1'b0, inh, dp, dl, b0);
        chk("to_inhibit_len", inh, INH);
        c = 0;
        while (tx_error !== 1'b1 && c < 3000) begin
            @(negedge CLOCK_50);
            c++;
        end
        chk("to_latency", c, TOUT);
        chk("to_err_code", err_code, ERR_TIMEOUT);
        repeat (5) @(negedge CLOCK_50);
        chk("to_fail_oe", snap_fail, 2'b00);
        chk("to_after_fail", snap_after, 3'b000);
        chk("to_err_held", err_code, ERR_TIMEOUT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
